// File: rtl/majo_vote_ctrl.sv
// majo_vote_ctrl: three-channel majority voter with collection timeout and saturating error counts
module majo_vote_ctrl #(
   parameter int TIMEOUT = 8,
   parameter int CNT_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             x_vld,
   input  logic             y_vld,
   input  logic             z_vld,
   input  logic             x,
   input  logic             y,
   input  logic             z,
   input  logic             out_rdy,
   output logic             out_vld,
   output logic             out,
   output logic [2:0]       fault,
   output logic [2:0]       missing,
   output logic [CNT_W-1:0] err_cnt_x,
   output logic [CNT_W-1:0] err_cnt_y,
   output logic [CNT_W-1:0] err_cnt_z,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, COLLECT, VOTE, HOLD} state_t;
   localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);
   state_t state, state_nxt;
   logic [7:0] timer;
   logic [2:0] vld, bits, cap, smp, cap_nxt, smp_nxt, cm, fault_v, inc;
   logic open, maj, accept;
   function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic e);
      return (e && c != '1) ? c + 1'b1 : c;
   endfunction
   assign vld     = {x_vld, y_vld, z_vld};
   assign bits    = {x, y, z};
   assign open    = (state == IDLE) || (state == COLLECT);
   assign accept  = (state == HOLD) && out_rdy;
   assign cap_nxt = open ? (cap | vld) : cap;
   // uncaptured slots may track the wire freely; only the first strobe freezes them
   assign smp_nxt = open ? ((cap & smp) | (~cap & bits)) : smp;
   assign cm      = cap & smp;
   assign maj     = (cm[2] & cm[1]) | (cm[2] & cm[0]) | (cm[1] & cm[0]);
   assign fault_v = cap & (smp ^ {3{maj}});
   assign inc     = fault_v | ~cap;
   assign busy    = state != IDLE;
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    state_nxt = &cap_nxt ? VOTE : (|vld ? COLLECT : IDLE);
         COLLECT: state_nxt = (&cap_nxt || timer == TLAST) ? VOTE : COLLECT;
         VOTE:    state_nxt = HOLD;
         HOLD:    state_nxt = out_rdy ? IDLE : HOLD;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         timer     <= '0;
         cap       <= '0;
         smp       <= '0;
         out_vld   <= 1'b0;
         out       <= 1'b0;
         fault     <= '0;
         missing   <= '0;
         err_cnt_x <= '0;
         err_cnt_y <= '0;
         err_cnt_z <= '0;
      end else begin
         state <= state_nxt;
         timer <= (state == COLLECT) ? timer + 8'd1 : '0;
         cap   <= accept ? '0 : cap_nxt;
         smp   <= smp_nxt;
         if (state == VOTE) begin
            out_vld   <= 1'b1;
            out       <= maj;
            fault     <= fault_v;
            missing   <= ~cap;
            err_cnt_x <= bump(err_cnt_x, inc[2]);
            err_cnt_y <= bump(err_cnt_y, inc[1]);
            err_cnt_z <= bump(err_cnt_z, inc[0]);
         end
         if (accept) begin
            out_vld <= 1'b0;
            fault   <= '0;
            missing <= '0;
         end
      end
   end
endmodule
